// File: rtl/seg_scan_2d_if.sv
// Handshake-free bus between the 2-digit scanner and its
// external nibble mux / display pins.
interface seg_scan_2d_if;
  logic       en;
  logic [3:0] mux_z;
  logic       sel;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  modport master (
    output en, mux_z,
    input  sel, seg, an, frame_tick
  );

  modport slave (
    input  en, mux_z,
    output sel, seg, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_2d.sv
// Two-digit multiplexed 7-segment scanner with blanking gaps
// between digits so segment data settles before anode enable.
module seg_scan_2d #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic         clk,
  input  logic         rst,
  seg_scan_2d_if.slave bus
);

  localparam int unsigned MAXL =
    (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int unsigned CW =
    (MAXL > 2) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    GAP0, SHOW0, GAP1, SHOW1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick_q, tick_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    tick_d  = 1'b0;
    if (!bus.en) begin
      state_d = GAP0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        GAP0: if (cnt_q == GAP_LAST) begin
          state_d = SHOW0;
          cnt_d   = '0;
        end
        SHOW0: if (cnt_q == SHOW_LAST) begin
          state_d = GAP1;
          cnt_d   = '0;
        end
        GAP1: if (cnt_q == GAP_LAST) begin
          state_d = SHOW1;
          cnt_d   = '0;
        end
        SHOW1: if (cnt_q == SHOW_LAST) begin
          state_d = GAP0;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register
  // in step with it; seg blanks whenever the digit is off.
  always_comb begin
    sel_d = 1'b0;
    an_d  = 2'b11;
    unique case (state_d)
      GAP0:  begin sel_d = 1'b0; an_d = 2'b11; end
      SHOW0: begin sel_d = 1'b0; an_d = 2'b10; end
      GAP1:  begin sel_d = 1'b1; an_d = 2'b11; end
      SHOW1: begin sel_d = 1'b1; an_d = 2'b01; end
    endcase
    seg_d = (an_d == 2'b11) ? 7'h7F : hex7(bus.mux_z);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GAP0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      an_q    <= 2'b11;
      seg_q   <= 7'h7F;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_2d.sv
// Bench for seg_scan_2d: frame-position reference model,
// directed vector tables and randomized mux/enable traffic.
module tb_seg_scan_2d;

  localparam int SD = 8;
  localparam int GC = 2;
  localparam int FR = 2 * (SD + GC);

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_t;

  typedef struct {
    logic [1:0] an;
    logic       sel;
    logic [6:0] seg;
    logic       tick;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_v = 4'h3;
  logic [3:0] b_v = 4'hA;
  int checks = 0;
  int failures = 0;
  logic mon = 1'b0;

  dec_t dtab [16];
  cyc_t ctab [21];

  seg_scan_2d_if bus();
  assign bus.mux_z = bus.sel ? b_v : a_v;

  seg_scan_2d #(.SCAN_DIV(SD), .GAP_CYC(GC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame position p: 0..GC-1 gap0, then show0, gap1, show1.
  function automatic logic [1:0] an_of(input int p);
    if (p < GC) return 2'b11;
    if (p < GC + SD) return 2'b10;
    if (p < 2 * GC + SD) return 2'b11;
    return 2'b01;
  endfunction

  function automatic logic sel_of(input int p);
    return p >= GC + SD;
  endfunction

  function automatic int nxt(input int p);
    return (p + 1) % FR;
  endfunction

  int         m_pos = 0;
  logic       m_tick = 1'b0;
  logic [6:0] m_seg = 7'h7F;

  always @(posedge clk or posedge rst) begin
    if (rst || !bus.en) begin
      m_pos  <= 0;
      m_tick <= 1'b0;
      m_seg  <= 7'h7F;
    end else begin
      m_pos  <= nxt(m_pos);
      m_tick <= (m_pos == FR - 1);
      m_seg  <= (an_of(nxt(m_pos)) == 2'b11) ? 7'h7F :
                dtab[sel_of(m_pos) ? b_v : a_v].seg;
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("model_an", bus.an, an_of(m_pos));
      chk("model_sel", bus.sel, sel_of(m_pos));
      chk("model_seg", bus.seg, m_seg);
      chk("model_tick", bus.frame_tick, m_tick);
      chk("an_not_00", bus.an == 2'b00, 0);
      chk("an_vs_sel",
          (bus.an == 2'b10 && bus.sel) ||
          (bus.an == 2'b01 && !bus.sel), 0);
    end
  end

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_pos != p && n < 4 * FR);
    if (m_pos != p) chk("wait_pos_timeout", m_pos, p);
  endtask

  initial begin
    int ticks[$];
    dtab = '{
      '{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
      '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
      '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
      '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}
    };
    for (int i = 0; i < 21; i++) begin
      if (i < 2)       ctab[i] = '{2'b11, 1'b0, 7'h7F, 1'b0};
      else if (i < 10) ctab[i] = '{2'b10, 1'b0, 7'h30, 1'b0};
      else if (i < 12) ctab[i] = '{2'b11, 1'b1, 7'h7F, 1'b0};
      else if (i < 20) ctab[i] = '{2'b01, 1'b1, 7'h08, 1'b0};
      else             ctab[i] = '{2'b11, 1'b0, 7'h7F, 1'b1};
    end

    bus.en = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_an", bus.an, 2'b11);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_sel", bus.sel, 1'b0);
    chk("rst_tick", bus.frame_tick, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mon = 1'b1;
    @(negedge clk);

    bus.en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("seq%0d_an", i), bus.an, ctab[i].an);
      chk($sformatf("seq%0d_sel", i), bus.sel, ctab[i].sel);
      chk($sformatf("seq%0d_seg", i), bus.seg, ctab[i].seg);
      chk($sformatf("seq%0d_tick", i), bus.frame_tick, ctab[i].tick);
    end

    for (int c = 1; c <= 3 * FR; c++) begin
      @(negedge clk);
      if (bus.frame_tick) begin
        ticks.push_back(c);
        chk("tick_at_gap0", {bus.an, bus.sel}, {2'b11, 1'b0});
      end
    end
    chk("tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      chk("tick_p0", ticks[0], FR);
      chk("tick_p1", ticks[1] - ticks[0], FR);
      chk("tick_p2", ticks[2] - ticks[1], FR);
    end

    for (int n = 0; n < 16; n++) begin
      wait_pos(0);
      a_v = dtab[n].nib;
      wait_pos(GC + 1);
      chk($sformatf("sweep_%0h", n), bus.seg, dtab[n].seg);
    end

    wait_pos(2 * GC + SD + 4);
    bus.en = 1'b0;
    @(negedge clk);
    chk("drop_an", bus.an, 2'b11);
    chk("drop_seg", bus.seg, 7'h7F);
    chk("drop_sel", bus.sel, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_an", bus.an, 2'b11);
    bus.en = 1'b1;
    @(negedge clk);
    chk("reen_an1", bus.an, 2'b11);
    @(negedge clk);
    chk("reen_an2", bus.an, 2'b10);

    wait_pos(GC + 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", bus.an, 2'b11);
    chk("arst_seg", bus.seg, 7'h7F);
    chk("arst_sel", bus.sel, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an1", bus.an, 2'b11);
    @(negedge clk);
    chk("post_rst_an2", bus.an, 2'b10);

    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) a_v = 4'($urandom);
      if ($urandom_range(3) == 0) b_v = 4'($urandom);
      bus.en = ($urandom_range(59) != 0);
    end

    @(negedge clk);
    mon = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_2d.md
SEG_SCAN_2D -- requirements
Module: seg_scan_2d

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit is shown per slot, legal range 2..2^20.
REQ-003 Parameter GAP_CYC, default 4: blanking cycles before each digit slot, legal range 1..255.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port en, input, 1 bit: scan enable; 0 forces the blanked idle state.
REQ-007 Port mux_z, input, 4 bits: selected nibble returned from the downstream 2:1 4-bit mux output z.
REQ-008 Port sel, output, 1 bit: drives the mux select; 0 selects input a (digit 0), 1 selects input b (digit 1).
REQ-009 Port seg, output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 Port an, output, 2 bits: active-low digit enables; an[0] is digit 0, an[1] is digit 1.
REQ-011 Port frame_tick, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-012 The FSM SHALL have the states GAP0, SHOW0, GAP1 and SHOW1, visited in that order in a loop while en=1.
REQ-013 GAP0 and GAP1 SHALL each last exactly GAP_CYC cycles; SHOW0 and SHOW1 SHALL each last exactly SCAN_DIV cycles; a frame is 2*(GAP_CYC+SCAN_DIV) cycles.
REQ-014 A single slot counter SHALL count from 0 to the state length minus 1, then return to 0 on the state transition; it SHALL never exceed the state length minus 1.
REQ-015 sel SHALL be a registered output: 0 in GAP0 and SHOW0, 1 in GAP1 and SHOW1. sel therefore changes on the first cycle of each GAP state.
REQ-016 an SHALL be registered: 2'b11 in both GAP states, 2'b10 in SHOW0, 2'b01 in SHOW1. At most one an bit SHALL be low in any cycle.
REQ-017 seg SHALL be registered every cycle from the hex decode of mux_z, one cycle of latency (mux treated as combinational), and SHALL be 7'h7F whenever the next an value is 2'b11.
REQ-018 The decode table SHALL be: 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E (hex, active-low).
REQ-019 Because GAP_CYC>=1, seg SHALL hold the value of the newly selected digit before an enables that digit; no ghosting cycle is permitted.
REQ-020 frame_tick SHALL be 1 for exactly the cycle following the last SHOW1 cycle (the first GAP0 cycle of the next frame), and 0 otherwise.
REQ-021 If en falls in any state, the next cycle SHALL be GAP0 with counter 0, sel=0, an=2'b11, seg=7'h7F and frame_tick=0; the FSM SHALL hold there while en=0.
REQ-022 When en rises, scanning SHALL start from GAP0 cycle 0, so the first SHOW0 cycle occurs GAP_CYC cycles later.
REQ-023 A change on mux_z mid-slot SHALL appear on seg one cycle later, with no other effect on timing.

Reset
REQ-024 While rst=1, outputs SHALL immediately (asynchronously) read: state GAP0, counter 0, sel=0, an=2'b11, seg=7'h7F, frame_tick=0.
REQ-025 Reset asserted mid-slot SHALL abort the slot. After release, operation SHALL resume per REQ-022 on the first clock edge with en=1.

Verification (SCAN_DIV=8, GAP_CYC=2, with the bench modelling the mux as a=4'h3, b=4'hA)
REQ-026 Reset, then en=1 -> an is 11,11 then 10 for 8 cycles (seg=7'h30), then 11,11 (sel=1), then 01 for 8 cycles (seg=7'h08); frame length is 20 cycles.
REQ-027 Free-running for 3 frames -> frame_tick pulses exactly every 20 cycles, each time coincident with GAP0 cycle 0.
REQ-028 Sweep a through 0..F over successive frames -> seg matches every table entry in REQ-018 during SHOW0.
REQ-029 Drop en in the 5th SHOW1 cycle -> next cycle an=11, seg=7F, sel=0; after re-enable, an=10 appears exactly 2 cycles later.
REQ-030 Assert rst asynchronously mid-SHOW0 -> an=11 and seg=7F before the next clock edge; normal sequence restarts after release.
REQ-031 Check every cycle -> an never equals 2'b00, and an is never low while seg is inconsistent with the current sel.
